instr_encoder: RTL and testbench

Streaming RV32I instruction encoder and program loader: the encode-side counterpart of the single-cycle control unit's decode. It accepts decoded fields (operation class, funct3, funct7 bit, registers, immediate) over a valid/ready handshake. It packs them into 32-bit instruction words and writes them sequentially into instruction memory through a registered write port. Testbenches and the boot path use it to build programs without hand-assembled hex.

---
 rtl/rv_pkg.sv | 32 +++
 rtl/instr_pack.sv | 93 +++++++++
 rtl/instr_encoder.sv | 125 ++++++++++++
 tb/tb_instr_encoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I encoder types: operation classes, opcodes, loader FSM states.
// Used by instr_pack and instr_encoder.
package rv_pkg;

  typedef enum logic [2:0] {
    C_IALU   = 3'd0,
    C_LOAD   = 3'd1,
    C_STORE  = 3'd2,
    C_BRANCH = 3'd3,
    C_JAL    = 3'd4,
    C_JALR   = 3'd5,
    C_REG    = 3'd6,
    C_RSVD   = 3'd7
  } opclass_t;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_REG    = 7'h33;

  localparam logic [31:0] ENC_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } enc_state_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packing for RV32I instruction classes.
// Optional immediate range check when ENC_RANGE_CHECK_EN is defined.
module instr_pack
  import rv_pkg::*;
(
  input  opclass_t    i_class,
  input  logic [2:0]  i_funct3,
  input  logic        i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_err
);

  logic w_shift;
  logic w_range_ok;

  // shift-immediate ops carry shamt plus funct7 bit 30
  assign w_shift = (i_funct3 == 3'd1) || (i_funct3 == 3'd5);

`ifdef ENC_RANGE_CHECK_EN
  logic w_fit12;
  logic w_fit13;
  logic w_fit21;
  logic w_shamt_ok;

  assign w_fit12 = (i_imm[31:11] == '0) || (i_imm[31:11] == '1);
  assign w_fit13 = (i_imm[31:12] == '0) || (i_imm[31:12] == '1);
  assign w_fit21 = (i_imm[31:20] == '0) || (i_imm[31:20] == '1);
  assign w_shamt_ok = (i_imm[31:5] == '0);

  // per-class immediate legality
  always_comb begin
    w_range_ok = 1'b1;
    unique case (i_class)
      C_IALU:   w_range_ok = w_shift ? w_shamt_ok : w_fit12;
      C_LOAD:   w_range_ok = w_fit12;
      C_STORE:  w_range_ok = w_fit12;
      C_BRANCH: w_range_ok = w_fit13 && !i_imm[0];
      C_JAL:    w_range_ok = w_fit21 && !i_imm[0];
      C_JALR:   w_range_ok = w_fit12;
      C_REG:    w_range_ok = 1'b1;
      C_RSVD:   w_range_ok = 1'b1;
    endcase
  end
`else
  logic w_unused_imm;
  assign w_unused_imm = ^i_imm[31:21];
  assign w_range_ok = 1'b1;
`endif

  // pack fields into the class's instruction format
  always_comb begin
    o_word = ENC_NOP;
    o_err  = 1'b0;
    unique case (i_class)
      C_IALU: begin
        if (w_shift)
          o_word = {1'b0, i_funct7, 5'b0, i_imm[4:0],
                    i_rs1, i_funct3, i_rd, OP_IMM};
        else
          o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_IMM};
      end
      C_LOAD:
        o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_LOAD};
      C_STORE:
        o_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3,
                  i_imm[4:0], OP_STORE};
      C_BRANCH:
        o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                  i_imm[4:1], i_imm[11], OP_BRANCH};
      C_JAL:
        o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                  i_rd, OP_JAL};
      C_JALR:
        o_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, OP_JALR};
      C_REG:
        o_word = {1'b0, i_funct7, 5'b0, i_rs2, i_rs1, i_funct3,
                  i_rd, OP_REG};
      C_RSVD: begin
        o_word = ENC_NOP;
        o_err  = 1'b1;
      end
    endcase
    if (!w_range_ok) begin
      o_word = ENC_NOP;
      o_err  = 1'b1;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder / program loader writing sequential words.
// Optional ENC_RANGE_CHECK_EN enables immediate range checking in instr_pack.
module instr_encoder
  import rv_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [2:0]    in_class,
  input  logic [2:0]    in_funct3,
  input  logic          in_funct7,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   count,
  output logic          done,
  output logic          error
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_LASTC = (AW+1)'(DEPTH - 1);

  enc_state_t    r_state;
  enc_state_t    w_next;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_count;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [31:0]   r_wdata;
  logic          r_done;
  logic          r_error;

  logic          w_ready;
  logic          w_fire;
  logic          w_full;
  logic          w_start_ok;
  logic          w_end;
  logic [31:0]   w_word;
  logic          w_err;

  instr_pack u_pack (
    .i_class  (opclass_t'(in_class)),
    .i_funct3 (in_funct3),
    .i_funct7 (in_funct7),
    .i_rd     (in_rd),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .i_imm    (in_imm),
    .o_word   (w_word),
    .o_err    (w_err)
  );

  assign w_ready    = (r_state == S_LOAD) && (r_count < LP_DEPTH);
  assign w_fire     = in_valid && w_ready;
  assign w_full     = (r_count == LP_LASTC);
  assign w_start_ok = start && (r_state != S_LOAD);
  assign w_end      = w_fire && (in_last || w_full);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next state: start opens a load, last or capacity closes it
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  if (w_end) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_LOAD;
      default: w_next = S_IDLE;
    endcase
  end

  // address/count tracking and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_we <= w_fire;
      if (w_start_ok) begin
        r_addr  <= base;
        r_count <= '0;
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end else if (w_fire) begin
        r_waddr <= r_addr;
        r_wdata <= w_word;
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count + 1'b1;
        if (w_end)
          r_done <= 1'b1;
        if (w_err || (w_full && !in_last))
          r_error <= 1'b1;
      end
    end
  end

  assign in_ready  = w_ready;
  assign mem_we    = r_we;
  assign mem_addr  = r_waddr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed field bundles, expected
// words queued at issue and compared by a write-port monitor.
module tb_instr_encoder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [2:0]    in_class;
  logic [2:0]    in_funct3;
  logic          in_funct7;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          done;
  logic          error;

  instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_class  (in_class),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [AW+31:0] sb_q[$];
  logic [AW+31:0] mon_e;
  logic [AW-1:0]  m_addr;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr %h data %h",
                 mem_addr, mem_wdata);
      end else begin
        mon_e = sb_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mon_e[AW+31:32]));
        check("wr_data", mem_wdata, mon_e[31:0]);
      end
    end
  end

  task automatic do_start(input logic [AW-1:0] b);
    @(negedge clk);
    base   = b;
    start  = 1'b1;
    m_addr = b;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic send(input logic [2:0] c, input logic [2:0] f3,
                      input logic f7, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic last,
                      input logic [31:0] exp);
    int k;
    in_class  = c;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = d;
    in_rs1    = s1;
    in_rs2    = s2;
    in_imm    = im;
    in_last   = last;
    in_valid  = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready 0 expected 1");
      in_valid = 1'b0;
    end else begin
      sb_q.push_back({m_addr, exp});
      m_addr = m_addr + 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_done(input int exp_count, input logic exp_err);
    int k;
    k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("done", 32'(done), 32'd1);
    check("count", 32'(count), 32'(exp_count));
    check("error", 32'(error), 32'(exp_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst = 1'b1; start = 1'b0; base = '0; in_valid = 1'b0;
    in_last = 1'b0; in_class = '0; in_funct3 = '0; in_funct7 = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; m_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst = 1'b0;

    // addi x1,x0,5 ; sub x3,x1,x2
    do_start(4'd0);
    send(3'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093);
    send(3'd6, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h4020_81B3);
    wait_done(2, 1'b0);

    // sw x2,12(x1) ; srai x5,x1,3 ; bne x1,x2,-8 ; jal x1,2048
    do_start(4'd0);
    send(3'd2, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12, 1'b0, 32'h0020_A623);
    send(3'd0, 3'd5, 1'b1, 5'd5, 5'd1, 5'd0, 32'd3, 1'b0, 32'h4030_D293);
    send(3'd3, 3'd1, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0,
         32'hFE20_9CE3);
    send(3'd4, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1,
         32'h0010_00EF);
    wait_done(4, 1'b0);

    // wrap from DEPTH-1 to 0; start mid-load must be ignored
    do_start(4'(DEPTH - 1));
    send(3'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h0010_0093);
    start = 1'b1;
    base  = 4'd5;
    send(3'd0, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b1, 32'h0020_0113);
    start = 1'b0;
    wait_done(2, 1'b0);

    // reserved class
    do_start(4'd0);
    send(3'd7, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd1, 1'b1, 32'h0000_0013);
    wait_done(1, 1'b1);

    // overflow: DEPTH+1 bundles without last
    do_start(4'd2);
    acc = 0;
    in_class = 3'd0; in_funct3 = 3'd0; in_funct7 = 1'b0;
    in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_last = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < DEPTH + 1; j++) begin
      in_imm = 32'(j);
      if (in_ready) begin
        sb_q.push_back({m_addr, 32'h0000_0093 | (32'(j) << 20)});
        m_addr = m_addr + 1'b1;
        acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("ovf_accepted", 32'(acc), 32'(DEPTH));
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_done", 32'(done), 32'd1);
    check("ovf_count", 32'(count), 32'(DEPTH));

`ifdef ENC_RANGE_CHECK_EN
    do_start(4'd0);
    send(3'd0, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1,
         32'h0000_0013);
    wait_done(1, 1'b1);
`endif

    // reset mid-load with in_valid held high
    do_start(4'd3);
    in_class = 3'd0; in_funct3 = 3'd0; in_funct7 = 1'b0;
    in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_last = 1'b0;
    in_imm = 32'd7;
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      if (!in_ready) begin
        n_checks++;
        n_fail++;
        $display("FAIL rst_load_ready: in_ready 0 expected 1");
      end else begin
        sb_q.push_back({m_addr, 32'h0070_0093});
        m_addr = m_addr + 1'b1;
      end
      @(negedge clk);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_mid_we", 32'(mem_we), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    do_start(4'd3);
    send(3'd1, 3'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'd8, 1'b0, 32'h0081_2203);
    send(3'd5, 3'd0, 1'b0, 5'd0, 5'd1, 5'd0, 32'd0, 1'b1, 32'h0000_8067);
    wait_done(2, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
